// File: rtl/mem_console_uart.sv
// Console peripheral for the picorv32 native bus: byte writes queue into a FIFO drained by an 8N1 UART.
// Optional MEM_CONSOLE_SIM_PRINT_EN echoes each pushed byte to the simulator console.
module mem_console_uart #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        uart_tx
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  tx_state_t     state, state_next;
  logic [BW-1:0] baud, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shifter, shift_next;
  logic          pop;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty;

  logic          hit, is_status, is_write, push_req, flush_req;
  logic          accept, push, flush;
  logic [31:0]   status;
  logic          unused_ok;

  assign unused_ok = ^{mem_addr[1:0], mem_wdata[31:8], mem_wstrb[3:1]};

  // Acceptance looks only at the registered count, so a push against a full
  // FIFO waits a cycle even when a pop frees a slot at the same edge.
  always_comb begin
    full       = (count == DEPTH_C);
    empty      = (count == '0);
    hit        = mem_valid && (mem_addr[31:3] == BASE_ADDR[31:3]);
    is_status  = mem_addr[2];
    is_write   = |mem_wstrb;
    push_req   = !is_status && mem_wstrb[0];
    flush_req  = is_status && mem_wstrb[0] && mem_wdata[0];
    accept     = hit && !mem_ready && !(push_req && full);
    push       = accept && push_req;
    flush      = accept && flush_req;
    status     = '0;
    status[0]  = empty;
    status[1]  = full;
    status[2]  = (state != IDLE);
    status[15:8] = 8'(count);
  end

  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_idx;
    shift_next = shifter;
    pop        = 1'b0;
    unique case (state)
      IDLE: if (!empty) begin
        pop        = 1'b1;
        shift_next = fifo_mem[rd_ptr];
        baud_next  = '0;
        bit_next   = '0;
        state_next = START;
      end
      START: if (baud == BAUD_LAST) begin
        baud_next  = '0;
        state_next = DATA;
      end else baud_next = baud + 1'b1;
      DATA: if (baud == BAUD_LAST) begin
        baud_next = '0;
        if (bit_idx == 3'd7) begin
          bit_next   = '0;
          state_next = STOP;
        end else begin
          bit_next   = bit_idx + 1'b1;
          shift_next = {1'b0, shifter[7:1]};
        end
      end else baud_next = baud + 1'b1;
      STOP: if (baud == BAUD_LAST) begin
        baud_next  = '0;
        state_next = IDLE;
      end else baud_next = baud + 1'b1;
      default: state_next = IDLE;
    endcase
  end

  assign uart_tx = (state != START) && ((state != DATA) || shifter[0]);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      shifter   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state     <= state_next;
      baud      <= baud_next;
      bit_idx   <= bit_next;
      shifter   <= shift_next;
      mem_ready <= accept;
      mem_rdata <= (accept && !is_write && is_status) ? status : '0;
      // Flush wins over a same-cycle pop; the popped byte is already in the shifter.
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
  end

`ifdef MEM_CONSOLE_SIM_PRINT_EN
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      if ((^mem_wdata[7:0]) === 1'bx) $write("X");
      else $write("%c", mem_wdata[7:0]);
    end
  end
`else
`endif

endmodule

// File: tb/tb_mem_console_uart.sv
// Directed bench for mem_console_uart with a 4-deep FIFO and 4 clocks per UART bit.
module tb_mem_console_uart;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        uart_tx;

  always #5 clock = ~clock;

  mem_console_uart #(.BASE_ADDR(BASE), .FIFO_DEPTH(4), .CLKS_PER_BIT(4)) dut (
    .clock(clock), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .uart_tx(uart_tx)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [8:0]  rx_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     output logic [31:0] rdata, output int lat);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    lat = 0;
    rdata = 'x;
    while (lat < 200) begin
      tick(1);
      lat++;
      if (mem_ready) begin
        rdata = mem_rdata;
        break;
      end
    end
    mem_valid = 1'b0; mem_wstrb = '0;
  endtask

  task automatic hold_access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                             input int n, output int seen);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    seen = 0;
    repeat (n) begin
      tick(1);
      if (mem_ready) seen++;
    end
    mem_valid = 1'b0; mem_wstrb = '0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      tick(1);
      c++;
    end
  endtask

  // Reference 8N1 receiver: samples each bit in its middle, stores {stop_bit, byte}.
  initial begin : rx
    logic [7:0] b;
    logic       stop;
    forever begin
      tick(1);
      if (uart_tx === 1'b0 && !reset) begin
        tick(6);
        b[0] = uart_tx;
        for (int j = 1; j < 8; j++) begin
          tick(4);
          b[j] = uart_tx;
        end
        tick(4);
        stop = uart_tx;
        rx_q.push_back({stop, b});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] rd;
    int          lat;
    int          seen;
    int          tx_low;
    logic [39:0] tx_s;
    logic [9:0]  frame;
    logic [7:0]  exp_lat [5];

    // Reset and idle
    tick(3);
    reset = 1'b0;
    check("reset uart_tx", 32'(uart_tx), 1);
    check("reset mem_ready", 32'(mem_ready), 0);
    seen = 0; tx_low = 0;
    repeat (20) begin
      tick(1);
      if (mem_ready !== 1'b0) seen++;
      if (uart_tx !== 1'b1) tx_low++;
    end
    check("idle ready", seen, 0);
    check("idle tx", tx_low, 0);
    bus(BASE + 4, 0, 4'b0000, rd, lat);
    check("status after reset", rd, 32'h1);
    check("status latency", lat, 1);
    bus(BASE, 0, 4'b0000, rd, lat);
    check("data read", rd, 32'h0);

    // Write without strobe 0: completes, no push; ready must not re-pulse while held
    tick(1);
    mem_valid = 1'b1; mem_addr = BASE; mem_wdata = 32'h99; mem_wstrb = 4'b0010;
    tick(1);
    check("ready pulse", 32'(mem_ready), 1);
    tick(1);
    check("ready forced low", 32'(mem_ready), 0);
    mem_valid = 1'b0; mem_wstrb = '0;
    tick(1);
    bus(BASE + 4, 0, 4'b0000, rd, lat);
    check("no push on wstrb1", rd, 32'h1);

    // Single frame, exact waveform, mid-frame status
    tick(1);
    rx_q.delete();
    bus(BASE, 32'h41, 4'b0001, rd, lat);
    check("write latency", lat, 1);
    for (int k = 0; k < 40; k++) begin
      tick(1);
      tx_s[k] = uart_tx;
      if (k == 10) begin
        mem_valid = 1'b1; mem_addr = BASE + 4; mem_wstrb = 4'b0000;
      end
      if (k == 11) begin
        check("mid ready", 32'(mem_ready), 1);
        check("mid status busy", mem_rdata, 32'h5);
        mem_valid = 1'b0;
      end
    end
    frame = {1'b1, 8'h41, 1'b0};
    for (int b = 0; b < 10; b++)
      check($sformatf("tx bit %0d", b), 32'(tx_s[4*b +: 4]), 32'({4{frame[b]}}));
    tick(1);
    bus(BASE + 4, 0, 4'b0000, rd, lat);
    check("status after frame", rd, 32'h1);
    check("rx count 0x41", rx_q.size(), 1);
    check("rx byte 0x41", 32'((rx_q.size() > 0) ? rx_q[0] : 9'h0), 32'h141);

    // Burst of 6 into a 4-deep FIFO; sixth write stalls until the second pop
    tick(1);
    rx_q.delete();
    exp_lat[0] = 8'd1; exp_lat[1] = 8'd2; exp_lat[2] = 8'd2; exp_lat[3] = 8'd2; exp_lat[4] = 8'd2;
    for (int i = 0; i < 5; i++) begin
      bus(BASE, 32'h30 + i, 4'b0001, rd, lat);
      check($sformatf("burst lat %0d", i), lat, 32'(exp_lat[i]));
    end
    bus(BASE + 4, 0, 4'b0000, rd, lat);
    check("status full", rd, 32'h0000_0406);
    bus(BASE, 32'h35, 4'b0001, rd, lat);
    check("stalled write lat", lat, 33);
    wait_rx(6, 400);
    check("burst rx count", rx_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("burst rx %0d", i), 32'((rx_q.size() > i) ? rx_q[i] : 9'h0), 32'h130 + i);

    // Flush with 3 queued and one in flight
    tick(10);
    rx_q.delete();
    for (int i = 0; i < 4; i++) bus(BASE, 32'h50 + i, 4'b0001, rd, lat);
    bus(BASE + 4, 32'h1, 4'b0001, rd, lat);
    check("flush lat", lat, 2);
    bus(BASE + 4, 0, 4'b0000, rd, lat);
    check("status after flush", rd, 32'h5);
    tick(120);
    check("flush rx count", rx_q.size(), 1);
    check("flush rx byte", 32'((rx_q.size() > 0) ? rx_q[0] : 9'h0), 32'h150);
    bus(BASE + 4, 0, 4'b0000, rd, lat);
    check("status idle after flush", rd, 32'h1);

    // Out-of-window accesses are ignored
    tick(1);
    rx_q.delete();
    hold_access(32'h1000_0008, 32'h77, 4'b1111, 8, seen);
    check("miss +8 ready", seen, 0);
    hold_access(32'h0000_0100, 32'h77, 4'b1111, 8, seen);
    check("miss ram ready", seen, 0);
    hold_access(32'h0FFF_FFFC, 32'h77, 4'b1111, 8, seen);
    check("miss below ready", seen, 0);
    bus(BASE + 4, 0, 4'b0000, rd, lat);
    check("status after misses", rd, 32'h1);
    tick(60);
    check("miss rx count", rx_q.size(), 0);

    // Reset in the middle of DATA
    tick(1);
    bus(BASE, 32'h55, 4'b0001, rd, lat);
    bus(BASE, 32'h66, 4'b0001, rd, lat);
    tick(8);
    check("pre-reset tx low", 32'(uart_tx), 0);
    reset = 1'b1;
    tick(1);
    check("reset mid-frame tx", 32'(uart_tx), 1);
    check("reset mid-frame ready", 32'(mem_ready), 0);
    reset = 1'b0;
    bus(BASE + 4, 0, 4'b0000, rd, lat);
    check("status after mid reset", rd, 32'h1);
    tick(60);
    rx_q.delete();
    bus(BASE, 32'h5A, 4'b0001, rd, lat);
    check("post-reset write lat", lat, 1);
    wait_rx(1, 100);
    tick(50);
    check("post-reset rx count", rx_q.size(), 1);
    check("post-reset rx byte", 32'((rx_q.size() > 0) ? rx_q[0] : 9'h0), 32'h15A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
